// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int unsigned MAX_MEM_LAT = 4;
    localparam int unsigned LAT_W       = 3;
    localparam int unsigned PERF_W      = 32;

endpackage

// File: rtl/dmem_arb_perf.sv
// Grant and stall event counters for the data-memory arbiter.
// Instantiated only when DMEM_ARB_PERF_EN is defined; counters wrap at 2^32.
module dmem_arb_perf
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_grant_i,
    input  logic              dbg_grant_i,
    input  logic              cpu_stall_i,
    output logic [PERF_W-1:0] perf_cpu_grants_o,
    output logic [PERF_W-1:0] perf_dbg_grants_o,
    output logic [PERF_W-1:0] perf_stall_cycles_o
);

    logic [PERF_W-1:0] cpu_grants_q, cpu_grants_d;
    logic [PERF_W-1:0] dbg_grants_q, dbg_grants_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        cpu_grants_d   = cpu_grants_q   + PERF_W'(cpu_grant_i);
        dbg_grants_d   = dbg_grants_q   + PERF_W'(dbg_grant_i);
        stall_cycles_d = stall_cycles_q + PERF_W'(cpu_stall_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_grants_q   <= '0;
            dbg_grants_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            cpu_grants_q   <= cpu_grants_d;
            dbg_grants_q   <= dbg_grants_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign perf_cpu_grants_o   = cpu_grants_q;
    assign perf_dbg_grants_o   = dbg_grants_q;
    assign perf_stall_cycles_o = stall_cycles_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the MEM-stage cpu port and the debug/loader port.
// Optional perf counters are enabled with the DMEM_ARB_PERF_EN macro.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ready_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_valid_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ready_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cpu_grants_o,
    output logic [PERF_W-1:0] perf_dbg_grants_o,
    output logic [PERF_W-1:0] perf_stall_cycles_o
`endif
);

    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    // Out-of-range latencies are clamped into the supported 1..MAX_MEM_LAT window.
    localparam int unsigned LAT_EFF  = (MEM_LAT == 0) ? 1 :
                                       ((MEM_LAT > MAX_MEM_LAT) ? MAX_MEM_LAT : MEM_LAT);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic grant_cpu, grant_dbg, read_grant, dbg_prio;

    // Grants are combinational off the registered state and forced low while in reset.
    assign dbg_prio   = (starve_q == STARVE_W'(STARVE_MAX));
    assign grant_dbg  = reset & (state_q == IDLE) & dbg_valid_i & (~cpu_valid_i | dbg_prio);
    assign grant_cpu  = reset & (state_q == IDLE) & cpu_valid_i & ~grant_dbg;
    assign read_grant = (grant_cpu & ~cpu_we_i) | (grant_dbg & ~dbg_we_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            lat_q        <= '0;
            starve_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_q        <= lat_d;
            starve_q     <= starve_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_d        = lat_q;
        starve_d     = starve_q;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (read_grant) begin
                    state_d = READ_WAIT;
                    owner_d = grant_dbg ? OWN_DBG : OWN_CPU;
                    lat_d   = LAT_W'(LAT_EFF);
                end
            end
            READ_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                // Last wait cycle: memory data is valid now, return it next cycle.
                if (lat_q == LAT_W'(1)) begin
                    state_d = IDLE;
                    if (owner_q == OWN_DBG) begin
                        dbg_rvalid_d = 1'b1;
                        dbg_rdata_d  = mem_rdata_i;
                    end else begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = mem_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!dbg_valid_i || grant_dbg) begin
            starve_d = '0;
        end else if (grant_cpu && !dbg_prio) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_comb begin
        cpu_ready_o = grant_cpu;
        dbg_ready_o = grant_dbg;
        mem_en_o    = grant_cpu | grant_dbg;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant_dbg) begin
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end else if (grant_cpu) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
        // Stall covers a blocked request and a cpu load from accept until its data returns.
        cpu_stall_o = reset & ((cpu_valid_i & ~grant_cpu) | (grant_cpu & ~cpu_we_i) |
                               ((state_q == READ_WAIT) & (owner_q == OWN_CPU)));
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_rdata_o  = dbg_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf u_perf (
        .clk                 (clk),
        .reset               (reset),
        .cpu_grant_i         (grant_cpu),
        .dbg_grant_i         (grant_dbg),
        .cpu_stall_i         (cpu_stall_o),
        .perf_cpu_grants_o   (perf_cpu_grants_o),
        .perf_dbg_grants_o   (perf_dbg_grants_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
    );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-level model, directed cases, random traffic.
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned TB_MEM_LAT = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              cpu_valid, cpu_we, cpu_ready, cpu_rvalid, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_valid, dbg_we, dbg_ready, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       perf_cpu_grants, perf_dbg_grants, perf_stall_cycles;
`endif

    dmem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (TB_MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid_i  (cpu_valid),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_ready_o  (cpu_ready),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_stall_o  (cpu_stall),
        .dbg_valid_i  (dbg_valid),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_ready_o  (dbg_ready),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_cpu_grants_o   (perf_cpu_grants),
        .perf_dbg_grants_o   (perf_dbg_grants),
        .perf_stall_cycles_o (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory with fixed read latency; garbage on the read bus when no read is returning.
    bit [DATA_W-1:0] mem [DEPTH];
    bit [DATA_W-1:0] rd_pipe [TB_MEM_LAT];
    always @(posedge clk) begin
        for (int k = TB_MEM_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : {$urandom, $urandom};
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = rd_pipe[TB_MEM_LAT-1];

    // Stimulus applied at the next falling edge
    logic              s_rst, s_cv, s_cwe, s_dv, s_dwe;
    logic [ADDR_W-1:0] s_caddr, s_daddr;
    logic [DATA_W-1:0] s_cwd, s_dwd;

    // Behavioural model state
    bit [DATA_W-1:0]   shadow [DEPTH];
    int unsigned       cyc, m_ret, m_starve;
    bit                m_pend, m_own_dbg;
    logic [DATA_W-1:0] m_pdata, m_rd_cpu, m_rd_dbg;
    int unsigned       m_pc, m_pd, m_ps;
    logic              last_gc, last_gd;

    int unsigned n_pass, n_checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    task automatic step();
        logic              e_crv, e_drv, e_st, e_en, e_we, gc, gd;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        @(negedge clk);
        reset     = s_rst;
        cpu_valid = s_cv;  cpu_we = s_cwe; cpu_addr = s_caddr; cpu_wdata = s_cwd;
        dbg_valid = s_dv;  dbg_we = s_dwe; dbg_addr = s_daddr; dbg_wdata = s_dwd;
        #1;
        e_crv = 1'b0; e_drv = 1'b0; e_st = 1'b0; e_en = 1'b0; e_we = 1'b0;
        gc = 1'b0; gd = 1'b0; e_addr = '0; e_wd = '0;
        if (!s_rst) begin
            m_pend = 1'b0; m_starve = 0; m_rd_cpu = '0; m_rd_dbg = '0;
            m_pc = 0; m_pd = 0; m_ps = 0;
        end else begin
            if (m_pend && m_ret == cyc) begin
                if (m_own_dbg) begin e_drv = 1'b1; m_rd_dbg = m_pdata; end
                else begin e_crv = 1'b1; m_rd_cpu = m_pdata; end
                m_pend = 1'b0;
            end
            gd = !m_pend && s_dv && (!s_cv || m_starve == STARVE_MAX);
            gc = !m_pend && s_cv && !gd;
            e_st = (s_cv && !gc) || (gc && !s_cwe) || (m_pend && !m_own_dbg);
            e_en = gc || gd;
            if (gd) begin e_we = s_dwe; e_addr = s_daddr; e_wd = s_dwd; end
            else if (gc) begin e_we = s_cwe; e_addr = s_caddr; e_wd = s_cwd; end
            if (!s_dv || gd) m_starve = 0;
            else if (gc && m_starve < STARVE_MAX) m_starve++;
            if (e_en && e_we) shadow[e_addr] = e_wd;
            if (e_en && !e_we) begin
                m_pend = 1'b1; m_own_dbg = gd; m_ret = cyc + TB_MEM_LAT + 1;
                m_pdata = shadow[e_addr];
            end
            m_pc += 32'(gc); m_pd += 32'(gd); m_ps += 32'(e_st);
        end
        chk("cpu_ready",  64'(cpu_ready),  64'(gc));
        chk("dbg_ready",  64'(dbg_ready),  64'(gd));
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_crv));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(e_drv));
        chk("cpu_rdata",  cpu_rdata,       m_rd_cpu);
        chk("dbg_rdata",  dbg_rdata,       m_rd_dbg);
        chk("cpu_stall",  64'(cpu_stall),  64'(e_st));
        chk("mem_en",     64'(mem_en),     64'(e_en));
        if (e_en || !s_rst) begin
            chk("mem_we",    64'(mem_we),   64'(e_we));
            chk("mem_addr",  64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", mem_wdata,     e_wd);
        end
`ifdef DMEM_ARB_PERF_EN
        chk("perf_cpu_grants",   64'(perf_cpu_grants),   64'(m_pc));
        chk("perf_dbg_grants",   64'(perf_dbg_grants),   64'(m_pd));
        chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(m_ps));
`endif
        last_gc = gc;
        last_gd = gd;
        cyc++;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return '1;
        if (r == 1) return '0;
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    initial begin
        clk = 1'b0;
        reset = 1'b0; cpu_valid = 1'b0; dbg_valid = 1'b0;
        cpu_we = 1'b0; dbg_we = 1'b0; cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
        n_pass = 0; n_checks = 0; cyc = 0; m_pend = 1'b0; m_own_dbg = 1'b0; m_ret = 0;
        m_starve = 0; m_pdata = '0; m_rd_cpu = '0; m_rd_dbg = '0; m_pc = 0; m_pd = 0; m_ps = 0;
        last_gc = 1'b0; last_gd = 1'b0;

        // Reset with a request already pending: everything must stay quiet
        s_rst = 1'b0; s_cv = 1'b1; s_cwe = 1'b0; s_caddr = 10'd7; s_cwd = '0;
        s_dv = 1'b0; s_dwe = 1'b0; s_daddr = '0; s_dwd = '0;
        step(); step();
        chk("lit_rst_ready",  64'(cpu_ready), 64'd0);
        chk("lit_rst_stall",  64'(cpu_stall), 64'd0);
        chk("lit_rst_mem_en", 64'(mem_en),    64'd0);
        chk("lit_rst_rdata",  cpu_rdata,      64'd0);

        // cpu store addr 5
        s_rst = 1'b1; s_cv = 1'b1; s_cwe = 1'b1; s_caddr = 10'd5; s_cwd = 64'h0000_0000_DEAD_BEEF;
        step();
        chk("lit_st_ready",  64'(cpu_ready),  64'd1);
        chk("lit_st_we",     64'(mem_we),     64'd1);
        chk("lit_st_addr",   64'(mem_addr),   64'd5);
        chk("lit_st_stall",  64'(cpu_stall),  64'd0);
        chk("lit_st_rvalid", 64'(cpu_rvalid), 64'd0);

        // cpu load addr 5: stall accept + 2 waits, data on 3rd cycle after accept
        s_cwe = 1'b0;
        step();
        chk("lit_ld_accept_stall", 64'(cpu_stall), 64'd1);
        s_cv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lit_ld_wait_stall", 64'(cpu_stall), 64'd1);
        end
        step();
        chk("lit_ld_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("lit_ld_rdata",  cpu_rdata,       64'h0000_0000_DEAD_BEEF);
        chk("lit_ld_stall",  64'(cpu_stall),  64'd0);

        // Both ports hammer writes: dbg wins once every STARVE_MAX+1 cycles
        s_cv = 1'b1; s_cwe = 1'b1; s_caddr = 10'd10; s_cwd = 64'd1;
        s_dv = 1'b1; s_dwe = 1'b1; s_daddr = 10'd11; s_dwd = 64'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lit_starve_cpu", 64'(cpu_ready), (i == 4 || i == 9) ? 64'd0 : 64'd1);
            chk("lit_starve_dbg", 64'(dbg_ready), (i == 4 || i == 9) ? 64'd1 : 64'd0);
        end
        s_cv = 1'b0; s_dv = 1'b0;
        step();

        // dbg load; cpu store arrives mid-wait and is granted alongside dbg_rvalid
        s_dv = 1'b1; s_dwe = 1'b0; s_daddr = 10'd5;
        step();
        chk("lit_dbg_ld_ready", 64'(dbg_ready), 64'd1);
        s_dv = 1'b0; s_cv = 1'b1; s_cwe = 1'b1; s_caddr = 10'd20; s_cwd = 64'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lit_hold_ready", 64'(cpu_ready), 64'd0);
            chk("lit_hold_stall", 64'(cpu_stall), 64'd1);
        end
        step();
        chk("lit_dbg_rvalid", 64'(dbg_rvalid), 64'd1);
        chk("lit_dbg_rdata",  dbg_rdata,       64'h0000_0000_DEAD_BEEF);
        chk("lit_hold_grant", 64'(cpu_ready),  64'd1);
        s_cv = 1'b0;

        // Reset in the middle of a cpu load drops it
        s_cv = 1'b1; s_cwe = 1'b0; s_caddr = 10'd5;
        step();
        s_cv = 1'b0;
        step();
        s_rst = 1'b0;
        step();
        chk("lit_midrst_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("lit_midrst_rdata",  cpu_rdata,       64'd0);
        chk("lit_midrst_stall",  64'(cpu_stall),  64'd0);
        s_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_dropped_rvalid", 64'(cpu_rvalid), 64'd0);
        end

        // 3 cpu writes, 1 dbg write, 1 cpu load after reset
        for (int i = 0; i < 3; i++) begin
            s_cv = 1'b1; s_cwe = 1'b1; s_caddr = ADDR_W'(30 + i); s_cwd = 64'h0123_4567_89AB_CDE0 + 64'(i);
            step();
        end
        s_cv = 1'b0; s_dv = 1'b1; s_dwe = 1'b1; s_daddr = 10'd33; s_dwd = 64'h55;
        step();
        s_dv = 1'b0; s_cv = 1'b1; s_cwe = 1'b0; s_caddr = 10'd30;
        step();
        s_cv = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("lit_post_rst_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("lit_post_rst_rdata",  cpu_rdata,       64'h0123_4567_89AB_CDE0);
`ifdef DMEM_ARB_PERF_EN
        chk("lit_perf_cpu",   64'(perf_cpu_grants),   64'd4);
        chk("lit_perf_dbg",   64'(perf_dbg_grants),   64'd1);
        chk("lit_perf_stall", 64'(perf_stall_cycles), 64'(1 + TB_MEM_LAT));
`endif

        // Random traffic with occasional async resets; requests held until granted
        for (int n = 0; n < 3000; n++) begin
            if (!s_rst) s_rst = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 499) == 0) s_rst = 1'b0;
            if (!s_cv || last_gc) begin
                s_cv = ($urandom_range(0, 99) < 60); s_cwe = 1'($urandom_range(0, 1));
                s_caddr = pick_addr(); s_cwd = {$urandom, $urandom};
            end
            if (!s_dv || last_gd) begin
                s_dv = ($urandom_range(0, 99) < 45); s_dwe = 1'($urandom_range(0, 1));
                s_daddr = pick_addr(); s_dwd = {$urandom, $urandom};
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
